// File: rtl/fccc_lock_monitor_pkg.sv
// rtl/fccc_lock_monitor_pkg.sv - state encoding, default parameters and sizing helper for the lock monitor
package fccc_mon_pkg;

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    STABLE = 2'd1,
    RUN    = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam int DEF_LOCK_SYNC_STAGES = 2;
  localparam int DEF_STABLE_CYCLES    = 1024;
  localparam int DEF_HOLD_CYCLES      = 16;
  localparam int DEF_LOSS_CNT_W       = 8;
  localparam int DEF_TIMEOUT_CYCLES   = 65536;

  // Counter width able to hold limit-1, never narrower than one bit.
  function automatic int clog2_min1(input int limit);
    return (limit <= 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/fccc_lock_monitor_if.sv
// rtl/fccc_lock_monitor_if.sv - lock input, loss-clear and status outputs of the lock monitor
interface fccc_lock_monitor_if #(
  parameter int LOSS_CNT_W = 8
);
  logic                  LOCK;
  logic                  CLR_LOSS;
  logic                  SYS_RESET;
  logic                  LOCKED;
  logic                  LOSS_PULSE;
  logic [LOSS_CNT_W-1:0] LOSS_COUNT;
  logic                  LOCK_TIMEOUT;

  modport master (
    output LOCK, CLR_LOSS,
    input  SYS_RESET, LOCKED, LOSS_PULSE, LOSS_COUNT, LOCK_TIMEOUT
  );

  modport slave (
    input  LOCK, CLR_LOSS,
    output SYS_RESET, LOCKED, LOSS_PULSE, LOSS_COUNT, LOCK_TIMEOUT
  );
endinterface

// File: rtl/fccc_lock_monitor_sync.sv
// rtl/fccc_lock_monitor_sync.sv - N-stage async-reset synchroniser for a single bit
module fccc_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  generate
    if (STAGES < 2) begin : g_bad_stages
      $error("fccc_sync: STAGES must be >= 2");
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/fccc_lock_monitor.sv
// rtl/fccc_lock_monitor.sv - qualifies FCCC LOCK, sequences downstream reset and logs lock losses
// Optional no-lock timeout flag built only when FCCC_LOCK_TIMEOUT_EN is defined.
module fccc_lock_monitor
  import fccc_mon_pkg::*;
#(
  parameter int LOCK_SYNC_STAGES = DEF_LOCK_SYNC_STAGES,
  parameter int STABLE_CYCLES    = DEF_STABLE_CYCLES,
  parameter int HOLD_CYCLES      = DEF_HOLD_CYCLES,
  parameter int LOSS_CNT_W       = DEF_LOSS_CNT_W,
  parameter int TIMEOUT_CYCLES   = DEF_TIMEOUT_CYCLES
) (
  input logic                GL0,
  input logic                RST,
  fccc_lock_monitor_if.slave mon
);

  localparam int CNT_W = clog2_min1((STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

  generate
    if (LOCK_SYNC_STAGES < 2) begin : g_bad_sync
      $error("fccc_lock_monitor: LOCK_SYNC_STAGES must be >= 2");
    end
    if (STABLE_CYCLES < 2) begin : g_bad_stable
      $error("fccc_lock_monitor: STABLE_CYCLES must be >= 2");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
      $error("fccc_lock_monitor: HOLD_CYCLES must be >= 1");
    end
    if (LOSS_CNT_W < 1) begin : g_bad_loss_w
      $error("fccc_lock_monitor: LOSS_CNT_W must be >= 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("fccc_lock_monitor: TIMEOUT_CYCLES must be >= 1");
    end
  endgenerate

  logic                  lock_s;
  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic                  sys_reset_q;
  logic                  locked_q;
  logic                  loss_pulse_q;
  logic [LOSS_CNT_W-1:0] loss_cnt_q;
  logic                  run_entry;
  logic                  loss_event;
  logic                  run_next;

  fccc_sync #(
    .STAGES (LOCK_SYNC_STAGES)
  ) u_lock_sync (
    .clk (GL0),
    .rst (RST),
    .d   (mon.LOCK),
    .q   (lock_s)
  );

  assign run_entry  = (state == STABLE) && lock_s && (cnt == STABLE_LAST);
  assign loss_event = (state == RUN) && !lock_s;
  assign run_next   = run_entry || ((state == RUN) && lock_s);

  always_ff @(posedge GL0 or posedge RST) begin
    if (RST) begin
      state        <= WAIT;
      cnt          <= '0;
      sys_reset_q  <= 1'b1;
      locked_q     <= 1'b0;
      loss_pulse_q <= 1'b0;
      loss_cnt_q   <= '0;
    end else begin
      case (state)
        WAIT: begin
          if (lock_s) begin
            state <= STABLE;
            cnt   <= '0;
          end
        end
        STABLE: begin
          // A bounce back to WAIT is part of qualification, not a loss event.
          if (!lock_s) begin
            state <= WAIT;
          end else if (cnt == STABLE_LAST) begin
            state <= RUN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (!lock_s) begin
            state <= HOLD;
            cnt   <= '0;
          end
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            state <= WAIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= WAIT;
          cnt   <= '0;
        end
      endcase

      sys_reset_q  <= !run_next;
      locked_q     <= run_next;
      loss_pulse_q <= loss_event;

      // A loss on the clearing edge survives the clear.
      if (mon.CLR_LOSS) begin
        loss_cnt_q <= loss_event ? LOSS_CNT_W'(1) : '0;
      end else if (loss_event && (loss_cnt_q != {LOSS_CNT_W{1'b1}})) begin
        loss_cnt_q <= loss_cnt_q + 1'b1;
      end
    end
  end

`ifdef FCCC_LOCK_TIMEOUT_EN
  localparam int TO_W = clog2_min1(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt;
  logic            to_flag;

  // Runs through every non-RUN state, so lock bounces cannot hide a stuck FCCC.
  always_ff @(posedge GL0 or posedge RST) begin
    if (RST) begin
      to_cnt  <= '0;
      to_flag <= 1'b0;
    end else if (run_entry) begin
      to_cnt  <= '0;
      to_flag <= 1'b0;
    end else if (state != RUN) begin
      if (to_cnt == TO_LAST) begin
        to_flag <= 1'b1;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  assign mon.LOCK_TIMEOUT = to_flag;
`else
  assign mon.LOCK_TIMEOUT = 1'b0;
`endif

  assign mon.SYS_RESET  = sys_reset_q;
  assign mon.LOCKED     = locked_q;
  assign mon.LOSS_PULSE = loss_pulse_q;
  assign mon.LOSS_COUNT = loss_cnt_q;

endmodule

// File: tb/tb_fccc_lock_monitor.sv
// tb/tb_fccc_lock_monitor.sv - directed self-checking bench for fccc_lock_monitor
module tb_fccc_lock_monitor;
  localparam int STABLE = 8;
  localparam int HOLD   = 4;
  localparam int CW     = 2;
  localparam int TO     = 20;
`ifdef FCCC_LOCK_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic GL0 = 1'b0;
  logic RST = 1'b1;
  int   passed = 0;
  int   total = 0;
  int   pulse_seen = 0;

  always #5 GL0 = ~GL0;

  fccc_lock_monitor_if #(.LOSS_CNT_W(CW)) mon_if ();

  fccc_lock_monitor #(
    .LOCK_SYNC_STAGES (2),
    .STABLE_CYCLES    (STABLE),
    .HOLD_CYCLES      (HOLD),
    .LOSS_CNT_W       (CW),
    .TIMEOUT_CYCLES   (TO)
  ) dut (
    .GL0 (GL0),
    .RST (RST),
    .mon (mon_if)
  );

  always @(negedge GL0) if (mon_if.LOSS_PULSE === 1'b1) pulse_seen++;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge GL0);
      #1;
    end
  endtask

  task automatic wait_fall(input int limit, output int fall);
    fall = 0;
    for (int e = 1; e <= limit && fall == 0; e++) begin
      tick(1);
      if (mon_if.SYS_RESET === 1'b0) fall = e;
    end
  endtask

  task automatic lose_lock();
    mon_if.LOCK = 1'b0;
    tick(1);
    mon_if.LOCK = 1'b1;
    tick(19);
  endtask

  task automatic test_reset();
    int fall;
    RST = 1'b1;
    mon_if.LOCK = 1'b1;
    mon_if.CLR_LOSS = 1'b0;
    tick(3);
    total++; if (mon_if.SYS_RESET !== 1'b1) $display("FAIL rst_sys_reset got %b want 1", mon_if.SYS_RESET); else passed++;
    total++; if (mon_if.LOCKED !== 1'b0) $display("FAIL rst_locked got %b want 0", mon_if.LOCKED); else passed++;
    total++; if (mon_if.LOSS_PULSE !== 1'b0) $display("FAIL rst_loss_pulse got %b want 0", mon_if.LOSS_PULSE); else passed++;
    total++; if (mon_if.LOSS_COUNT !== 2'd0) $display("FAIL rst_loss_count got %0d want 0", mon_if.LOSS_COUNT); else passed++;
    total++; if (mon_if.LOCK_TIMEOUT !== 1'b0) $display("FAIL rst_timeout got %b want 0", mon_if.LOCK_TIMEOUT); else passed++;
    RST = 1'b0;
    wait_fall(30, fall);
    total++; if (fall != 11) $display("FAIL release_edge got %0d want 11", fall); else passed++;
    total++; if (mon_if.LOCKED !== 1'b1) $display("FAIL release_locked got %b want 1", mon_if.LOCKED); else passed++;
  endtask

  task automatic test_glitch();
    int fall;
    int p0;
    RST = 1'b1;
    mon_if.LOCK = 1'b1;
    tick(1);
    RST = 1'b0;
    tick(5);
    p0 = pulse_seen;
    mon_if.LOCK = 1'b0;
    tick(3);
    mon_if.LOCK = 1'b1;
    total++; if (mon_if.SYS_RESET !== 1'b1) $display("FAIL glitch_held got %b want 1", mon_if.SYS_RESET); else passed++;
    wait_fall(30, fall);
    total++; if (fall != 11) $display("FAIL glitch_restart_edge got %0d want 11", fall); else passed++;
    total++; if (mon_if.LOSS_COUNT !== 2'd0) $display("FAIL glitch_loss_count got %0d want 0", mon_if.LOSS_COUNT); else passed++;
    total++; if (pulse_seen - p0 != 0) $display("FAIL glitch_pulses got %0d want 0", pulse_seen - p0); else passed++;
  endtask

  task automatic test_loss();
    int rise;
    int fall;
    int p0;
    tick(2);
    p0 = pulse_seen;
    rise = 0;
    fall = 0;
    mon_if.LOCK = 1'b0;
    for (int e = 1; e <= 30; e++) begin
      tick(1);
      if (e == 1) mon_if.LOCK = 1'b1;
      if (rise == 0 && mon_if.SYS_RESET === 1'b1) rise = e;
      if (rise != 0 && fall == 0 && mon_if.SYS_RESET === 1'b0) fall = e;
    end
    total++; if (rise != 3) $display("FAIL loss_reset_edge got %0d want 3", rise); else passed++;
    total++; if (fall != 16) $display("FAIL loss_rerelease_edge got %0d want 16", fall); else passed++;
    total++; if (pulse_seen - p0 != 1) $display("FAIL loss_pulses got %0d want 1", pulse_seen - p0); else passed++;
    total++; if (mon_if.LOSS_COUNT !== 2'd1) $display("FAIL loss_count got %0d want 1", mon_if.LOSS_COUNT); else passed++;
    total++; if (mon_if.LOCKED !== 1'b1) $display("FAIL loss_relocked got %b want 1", mon_if.LOCKED); else passed++;
  endtask

  task automatic test_saturate();
    int p0;
    p0 = pulse_seen;
    repeat (4) lose_lock();
    total++; if (mon_if.LOSS_COUNT !== 2'd3) $display("FAIL sat_count got %0d want 3", mon_if.LOSS_COUNT); else passed++;
    total++; if (pulse_seen - p0 != 4) $display("FAIL sat_pulses got %0d want 4", pulse_seen - p0); else passed++;
    mon_if.LOCK = 1'b0;
    tick(1);
    mon_if.LOCK = 1'b1;
    tick(1);
    mon_if.CLR_LOSS = 1'b1;
    tick(1);
    mon_if.CLR_LOSS = 1'b0;
    total++; if (mon_if.LOSS_COUNT !== 2'd1) $display("FAIL clr_with_event got %0d want 1", mon_if.LOSS_COUNT); else passed++;
    total++; if (mon_if.LOSS_PULSE !== 1'b1) $display("FAIL clr_event_pulse got %b want 1", mon_if.LOSS_PULSE); else passed++;
    tick(17);
    mon_if.CLR_LOSS = 1'b1;
    tick(1);
    mon_if.CLR_LOSS = 1'b0;
    total++; if (mon_if.LOSS_COUNT !== 2'd0) $display("FAIL clr_plain got %0d want 0", mon_if.LOSS_COUNT); else passed++;
  endtask

  task automatic test_async_reset();
    int p0;
    lose_lock();
    total++; if (mon_if.SYS_RESET !== 1'b0) $display("FAIL pre_rst_run got %b want 0", mon_if.SYS_RESET); else passed++;
    p0 = pulse_seen;
    #2;
    RST = 1'b1;
    #1;
    total++; if (mon_if.SYS_RESET !== 1'b1) $display("FAIL async_sys_reset got %b want 1", mon_if.SYS_RESET); else passed++;
    total++; if (mon_if.LOCKED !== 1'b0) $display("FAIL async_locked got %b want 0", mon_if.LOCKED); else passed++;
    total++; if (mon_if.LOSS_COUNT !== 2'd0) $display("FAIL async_loss_count got %0d want 0", mon_if.LOSS_COUNT); else passed++;
    tick(3);
    total++; if (pulse_seen - p0 != 0) $display("FAIL async_pulses got %0d want 0", pulse_seen - p0); else passed++;
  endtask

  task automatic test_timeout();
    RST = 1'b1;
    mon_if.LOCK = 1'b0;
    tick(1);
    RST = 1'b0;
    tick(19);
    total++; if (mon_if.LOCK_TIMEOUT !== 1'b0) $display("FAIL timeout_early got %b want 0", mon_if.LOCK_TIMEOUT); else passed++;
    tick(1);
    total++; if (mon_if.LOCK_TIMEOUT !== TO_EN) $display("FAIL timeout_set got %b want %b", mon_if.LOCK_TIMEOUT, TO_EN); else passed++;
    mon_if.LOCK = 1'b1;
    tick(10);
    total++; if (mon_if.LOCK_TIMEOUT !== TO_EN) $display("FAIL timeout_sticky got %b want %b", mon_if.LOCK_TIMEOUT, TO_EN); else passed++;
    tick(1);
    total++; if (mon_if.SYS_RESET !== 1'b0) $display("FAIL timeout_run got %b want 0", mon_if.SYS_RESET); else passed++;
    total++; if (mon_if.LOCK_TIMEOUT !== 1'b0) $display("FAIL timeout_clear got %b want 0", mon_if.LOCK_TIMEOUT); else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    mon_if.LOCK = 1'b0;
    mon_if.CLR_LOSS = 1'b0;
    #1;
    test_reset();
    test_glitch();
    test_loss();
    test_saturate();
    test_async_reset();
    test_timeout();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
